// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operation encodings,
// NZCV bit positions and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int NREQ      = 2;

  // ALUControl encodings as presented by each requester.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  // Bit positions inside a 4-bit NZCV vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

  // Assemble an NZCV vector from its individual bits.
  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the shared ALU.
// Requester slices are packed side by side: slice i belongs to requester i.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_srca;
  logic [2*WIDTH-1:0] req_srcb;
  logic [3:0]         req_ctrl;
  logic [1:0]         req_setflags;

  logic               rsp_valid;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_result;
  logic [3:0]         rsp_flags;
  logic [3:0]         flags_q;
  logic               busy;

  // Requester / control side.
  modport master (
    output req_valid, req_srca, req_srcb, req_ctrl, req_setflags,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_srca, req_srcb, req_ctrl, req_setflags,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q, busy
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: ADD/SUB/AND/ORR with NZCV generation.
// SUB is A + ~B + 1, so C=1 means "no borrow".
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  alu_ctrl_e        alu_control,
  output logic [WIDTH-1:0] alu_result,
  output nzcv_t            alu_flags
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             overflow;

  // Shared adder for ADD/SUB; the subtract path inverts B and injects the +1.
  always_comb begin
    is_sub = (alu_control == ALU_SUB);
    b_eff  = is_sub ? ~src_b : src_b;
    sum    = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  end

  // Result select and flag generation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    alu_result = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_SUB: begin
        alu_result = sum[WIDTH-1:0];
        carry      = sum[WIDTH];
        // Signed overflow: both adder inputs agree in sign, result differs.
        // With b_eff = ~B this also covers the SUB rule (A and B disagree).
        overflow   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = '0;
    endcase
    alu_flags = pack_nzcv(alu_result[WIDTH-1], (alu_result == '0), carry, overflow);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. One operation is granted per cycle
// with round-robin on contention; results and NZCV are registered one cycle
// later, and an architectural flags register is updated only by accepted
// requests that ask for it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic             rr_ptr;
  logic             both_valid;
  logic             any_valid;
  logic             gnt_idx;
  logic [1:0]       grant;
  logic             accept;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  alu_ctrl_e        op_ctrl;
  logic             op_setflags;

  logic [WIDTH-1:0] alu_result;
  nzcv_t            alu_flags;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  nzcv_t            rsp_flags_q;
  nzcv_t            flags_q;

  // Grant selection: a lone requester wins outright, a contested cycle goes
  // to rr_ptr. Grants are suppressed while reset is held.
  always_comb begin
    both_valid = &bus.req_valid;
    any_valid  = |bus.req_valid;
    gnt_idx    = both_valid ? rr_ptr : bus.req_valid[1];
    grant      = '0;
    if (any_valid && !reset) grant[gnt_idx] = 1'b1;
  end

  // grant is only ever raised on a valid requester, so it is the accept vector.
  assign accept = |grant;

  // Route the winning requester's operands and control to the shared ALU.
  always_comb begin
    op_a        = gnt_idx ? bus.req_srca[2*WIDTH-1:WIDTH] : bus.req_srca[WIDTH-1:0];
    op_b        = gnt_idx ? bus.req_srcb[2*WIDTH-1:WIDTH] : bus.req_srcb[WIDTH-1:0];
    op_ctrl     = alu_ctrl_e'(gnt_idx ? bus.req_ctrl[3:2] : bus.req_ctrl[1:0]);
    op_setflags = bus.req_setflags[gnt_idx];
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .src_a       (op_a),
    .src_b       (op_b),
    .alu_control (op_ctrl),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  // Response/flags registers and round-robin pointer; reset drops any
  // in-flight response immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
      rr_ptr       <= 1'b0;
    end else begin
      // NOTE: state is written with <= so every register samples the
      // pre-edge values; blocking writes here would make ordering matter.
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_id_q     <= gnt_idx;
        rsp_result_q <= alu_result;
        rsp_flags_q  <= alu_flags;
        if (op_setflags) flags_q <= alu_flags;
        // Only a contested grant moves the pointer, handing the next
        // contested cycle to the loser.
        if (both_valid) rr_ptr <= ~gnt_idx;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.flags_q    = flags_q;
  assign bus.busy       = rsp_valid_q | any_valid;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath between two requesters:
  - port 0: main instruction datapath;
  - port 1: secondary requester, e.g. address generation or a debug/test engine.
- Arbitrates one operation per cycle using round-robin with a sticky hold.
- Registers the result and NZCV flags, and keeps an architectural flags register updated only by requests that ask for it.
- Sits between the decode/control logic and the ALU.

Parameters:
- WIDTH, 32, operand/result width.
- NREQ, 2, number of requesters (fixed at 2 for this revision).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant/accept, combinational from req_valid and rr_ptr.
- req_srca  in  2*WIDTH  operand A; slice i belongs to requester i.
- req_srcb  in  2*WIDTH  operand B; slice i belongs to requester i.
- req_ctrl  in  4  ALUControl, 2 bits per requester: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- req_setflags  in  2  commit the result's flags to flags_q when accepted.
- rsp_valid  out  1  result valid, exactly one cycle after acceptance.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  WIDTH  registered ALU result.
- rsp_flags  out  4  registered NZCV of this operation: [3]N [2]Z [1]C [0]V.
- flags_q  out  4  architectural NZCV register.
- busy  out  1  high while rsp_valid is high or any req_valid is high.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, flags_q=0, rr_ptr=0.
  - req_ready is 0 while reset is asserted.
- Arbitration, evaluated each cycle:
  - Exactly one valid requester: grant it.
  - Both valid: grant requester rr_ptr.
  - Neither valid: no grant, no state change.
  - At most one req_ready bit is high per cycle.
  - Acceptance = req_valid[i] & req_ready[i].
- rr_ptr update:
  - After a contested grant (both valid), rr_ptr <= ~granted index.
  - After an uncontested grant, rr_ptr is unchanged.
  - This guarantees no starvation: under continuous contention, grants alternate.
- Execution:
  - The granted operands and control drive one ALU instance combinationally.
  - Outputs are registered on the next clk edge, so latency is 1 cycle and throughput is 1 op/cycle.
  - No backpressure on the response side: rsp_* is valid for exactly one cycle and the consumer must capture it.
- Arithmetic and flag rules (WIDTH-bit, two's complement):
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - ADD: C = carry out of bit WIDTH-1; V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB: computed as A + ~B + 1. C = carry out, i.e. 1 means no borrow. V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - AND/ORR: C=0, V=0.
- Flags register:
  - On accept with req_setflags[granted]=1, flags_q <= the NZCV of that op, updated on the same edge as rsp_*.
  - Otherwise flags_q holds.
  - Requests that are not granted never touch flags_q.
- Idle cycles: rsp_valid=0; rsp_result and rsp_flags hold their last values.
- Held requests: a requester not granted keeps req_valid and its operands stable until accepted. Inputs changing while unaccepted is illegal; the bench asserts on it.
- Reset mid-operation: an in-flight response is dropped (rsp_valid forced to 0) and is never delivered after reset deasserts. flags_q returns to 0.
- Back-to-back operations: an operation that depends on flags_q sees the value updated by the prior accepted setflags op one cycle after that op's acceptance.

Decomposition:
- Shared package alu_pkg:
  - ALUControl encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_ORR=2'b11.
  - NZCV bit index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - WIDTH default.
- Sub-module: one combinational core, alu_core (SrcA, SrcB, ALUControl -> ALUResult, ALUFlags), implementing the flag rules above.
- The arbiter keeps arbitration, registers and flags_q.

Test Plan:
- Reset then single request:
  - Stimulus: req0 ADD 0x00000005 + 0x00000003, setflags=1.
  - Required: next cycle rsp_valid=1, rsp_id=0, rsp_result=0x00000008, rsp_flags=0000, flags_q=0000.
- Overflow and carry:
  - req1 ADD 0x7FFFFFFF + 0x00000001, setflags=1 -> rsp_result=0x80000000, NZCV=1001.
  - Then req1 ADD 0xFFFFFFFF + 0x00000001, setflags=1 -> result 0, NZCV=0110.
- SUB without setflags:
  - req0 SUB 3 - 5, setflags=0 -> rsp_result=0xFFFFFFFE, rsp_flags=1000 (C=0, borrow).
  - flags_q is unchanged from the previous value.
- Contention:
  - Both valid for 4 consecutive cycles with rr_ptr=0 -> grant order 0,1,0,1.
  - rsp_id follows the same sequence one cycle later; never two req_ready bits high at once.
- Logic ops:
  - req0 AND 0xF0F0F0F0 & 0x0F0F0F0F -> result 0, NZCV=0100.
  - req0 ORR of the same operands -> 0xFFFFFFFF, NZCV=1000.
- Async reset mid-flight:
  - Accept an op, then assert reset before the next clk edge -> rsp_valid=0 and flags_q=0 immediately.
  - No response appears after reset deasserts.
